// File: rtl/mac_pkg.sv
// mac_pkg: MAC constants shared by transmit and receive paths, CRC-32 parameters and transmit FSM states
package mac_pkg;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD           = 8'hD5;
    localparam int          PREAMBLE_LEN  = 7;
    localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_DATA, S_PAD, S_FCS, S_IPG} tx_state_t;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction
endpackage

// File: rtl/rgmii_tx_framer_if.sv
// rgmii_tx_framer_if: Avalon-ST style byte stream with ready backpressure
// Signals: startofpacket, endofpacket, valid, data, error (source -> sink); ready (sink -> source)
// Modports: master = stream source, slave = stream sink (the framer)
interface rgmii_tx_framer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  startofpacket;
    logic                  endofpacket;
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic                  error;
    logic                  ready;

    modport master (output startofpacket, endofpacket, valid, data, error, input ready);
    modport slave  (input startofpacket, endofpacket, valid, data, error, output ready);
endinterface

// File: rtl/crc32_d8.sv
// crc32_d8: combinational byte-wide CRC-32 (IEEE 802.3, reflected) next-state function
// Ports: crc_in current CRC register, data next byte (LSB first on the wire), crc_out updated register
module crc32_d8
    import mac_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);
    localparam logic [31:0] POLY_R = reflect32(CRC32_POLY);

    logic [31:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++)
            c = {1'b0, c[31:1]} ^ ((c[0] ^ data[i]) ? POLY_R : 32'h0);
        crc_out = c;
    end
endmodule

// File: rtl/rgmii_tx_framer.sv
// rgmii_tx_framer: GMII transmit framer adding preamble/SFD, minimum-length padding, optional FCS and IPG
// Ports: mac_clk / mac_rst_n clock and asynchronous active-low reset;
//        mac (slave) Avalon-ST byte stream with ready;
//        gmii_txd / gmii_tx_en / gmii_tx_er registered GMII byte stream.
// Build option: define RGMII_TX_FCS_EN to append the CRC-32 FCS; otherwise upstream supplies it.
module rgmii_tx_framer
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int IPG_BYTES       = 12,
    parameter int MIN_FRAME_BYTES = 60
) (
    input  logic             mac_clk,
    input  logic             mac_rst_n,
    rgmii_tx_framer_if.slave mac,
    output logic [7:0]       gmii_txd,
    output logic             gmii_tx_en,
    output logic             gmii_tx_er
);
    localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME_BYTES);
    localparam logic [15:0] IPG_LAST = 16'(IPG_BYTES - 1);
    localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN);
`ifdef RGMII_TX_FCS_EN
    localparam tx_state_t TAIL = S_FCS;
`else
    localparam tx_state_t TAIL = S_IPG;
`endif

    tx_state_t             state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [7:0]            txd_q, txd_d;
    logic                  tx_en_q, tx_en_d, tx_er_q, tx_er_d;
    logic [DATA_WIDTH-1:0] beat;
    logic                  sop_seen;

    assign beat      = mac.data;
    assign sop_seen  = mac.valid && mac.startofpacket;
    // Idle flushes stray non-SOP beats; a SOP is held until the preamble is out.
    assign mac.ready = mac_rst_n && (state_q == S_DATA || (state_q == S_IDLE && !mac.startofpacket));

    always_ff @(posedge mac_clk or negedge mac_rst_n)
        if (!mac_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            txd_q   <= 8'h00;
            tx_en_q <= 1'b0;
            tx_er_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            txd_q   <= txd_d;
            tx_en_q <= tx_en_d;
            tx_er_q <= tx_er_d;
        end

    // cnt_q: preamble byte index, then payload length (saturating), then FCS byte / IPG cycle index.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (sop_seen) begin
                state_d = S_PREAMBLE;
                cnt_d   = 16'd1;
            end
            S_PREAMBLE: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == PRE_LAST) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                cnt_d = cnt_q < MIN_LEN ? cnt_q + 16'd1 : cnt_q;
                if (!mac.valid) begin
                    state_d = S_IPG;
                    cnt_d   = '0;
                end else if (mac.endofpacket) begin
                    state_d = cnt_d < MIN_LEN ? S_PAD : TAIL;
                    cnt_d   = cnt_d < MIN_LEN ? cnt_d : '0;
                end
            end
            S_PAD: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_d == MIN_LEN) begin
                    state_d = TAIL;
                    cnt_d   = '0;
                end
            end
`ifdef RGMII_TX_FCS_EN
            S_FCS: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == 16'd3) begin
                    state_d = S_IPG;
                    cnt_d   = '0;
                end
            end
`endif
            S_IPG: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == IPG_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef RGMII_TX_FCS_EN
    logic [31:0] crc_q, crc_d, crc_nx;
    logic [7:0]  fcs_byte;

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data    (state_q == S_PAD ? 8'h00 : beat[7:0]),
        .crc_out (crc_nx)
    );

    // Errored beats still feed the CRC; FCS goes out complemented, LSB byte first.
    assign fcs_byte = ~crc_q[{cnt_q[1:0], 3'b000} +: 8];

    always_comb
        crc_d = state_q == S_IDLE ? CRC32_INIT :
                ((state_q == S_DATA && mac.valid) || state_q == S_PAD) ? crc_nx : crc_q;

    always_ff @(posedge mac_clk or negedge mac_rst_n)
        if (!mac_rst_n) crc_q <= CRC32_INIT;
        else            crc_q <= crc_d;
`endif

    // Outputs are computed one cycle ahead and registered; underrun emits a single errored 0x00.
    always_comb begin
        tx_en_d = state_q inside {S_PREAMBLE, S_DATA, S_PAD, S_FCS} || (state_q == S_IDLE && sop_seen);
        tx_er_d = state_q == S_DATA && (!mac.valid || mac.error);
        case (state_q)
            S_IDLE:     txd_d = sop_seen ? PREAMBLE_BYTE : 8'h00;
            S_PREAMBLE: txd_d = cnt_q == PRE_LAST ? SFD : PREAMBLE_BYTE;
            S_DATA:     txd_d = mac.valid ? beat[7:0] : 8'h00;
`ifdef RGMII_TX_FCS_EN
            S_FCS:      txd_d = fcs_byte;
`endif
            default:    txd_d = 8'h00;
        endcase
    end

    assign gmii_txd   = txd_q;
    assign gmii_tx_en = tx_en_q;
    assign gmii_tx_er = tx_er_q;
endmodule

// File: tb/tb_rgmii_tx_framer.sv
// tb_rgmii_tx_framer: randomized self-checking bench for rgmii_tx_framer against a frame-level reference model
module tb_rgmii_tx_framer;
    import mac_pkg::*;

    localparam int IPG = 12;
    localparam int MIN = 60;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #4 clk = ~clk;

    rgmii_tx_framer_if #(.DATA_WIDTH(8)) mac ();
    logic [7:0] txd;
    logic       tx_en, tx_er;

    rgmii_tx_framer #(.DATA_WIDTH(8), .IPG_BYTES(IPG), .MIN_FRAME_BYTES(MIN)) dut (
        .mac_clk    (clk),
        .mac_rst_n  (rst_n),
        .mac        (mac),
        .gmii_txd   (txd),
        .gmii_tx_en (tx_en),
        .gmii_tx_er (tx_er)
    );

    logic [31:0] kat_c, kat_o;
    logic [7:0]  kat_d;
    crc32_d8 u_kat (.crc_in(kat_c), .data(kat_d), .crc_out(kat_o));

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [8:0] got_q[$];
    int         len_q[$];
    int         gap_q[$];
    int         bad_idle;

    initial begin
        int  cur_len, idle;
        bit  prev_en, have_prev;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                got_q.delete(); len_q.delete(); gap_q.delete();
                cur_len = 0; idle = 0; bad_idle = 0; prev_en = 0; have_prev = 0;
            end else if (tx_en) begin
                if (!prev_en && have_prev) gap_q.push_back(idle);
                got_q.push_back({tx_er, txd});
                cur_len++;
                prev_en = 1;
            end else begin
                if (prev_en) begin
                    len_q.push_back(cur_len);
                    cur_len = 0; idle = 0; have_prev = 1;
                end
                idle++;
                prev_en = 0;
                if (txd != 8'h00 || tx_er) bad_idle++;
            end
        end
    end

    logic [8:0] exp_q[$];
    int         exp_len[$];
    int         exp_gap[$];
    int         npk;

`ifdef RGMII_TX_FCS_EN
    // Straight polynomial division, bits taken LSB first, register reflected at the end.
    function automatic logic [31:0] fcs_ref(input logic [7:0] b[$]);
        logic [31:0] r, o;
        r = CRC32_INIT;
        foreach (b[j])
            for (int i = 0; i < 8; i++)
                r = {r[30:0], 1'b0} ^ ((r[31] ^ b[j][i]) ? CRC32_POLY : 32'h0);
        for (int i = 0; i < 32; i++) o[i] = r[31-i];
        return ~o;
    endfunction
`endif

    task automatic do_reset();
        mac.valid = 0; mac.startofpacket = 0; mac.endofpacket = 0; mac.data = 8'h00; mac.error = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        exp_q.delete(); exp_len.delete(); exp_gap.delete();
        npk = 0;
    endtask

    task automatic beat(input logic sop, input logic eop, input logic [7:0] d, input logic e, output bit ok);
        logic r;
        mac.valid = 1; mac.startofpacket = sop; mac.endofpacket = eop; mac.data = d; mac.error = e;
        ok = 0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            r = mac.ready;
            @(posedge clk);
            #1;
            if (r) begin
                ok = 1;
                break;
            end
        end
    endtask

    // mode: 0 random bytes, 1 incrementing from 0, 2 ASCII "123..."; und>0 drops valid after und beats.
    task automatic send_pkt(input int n, input int mode, input int und, input int err_at, input int strays);
        logic [7:0] pl[$];
        logic [7:0] fr[$];
        bit ok;
        int k, len;
        for (int s = 0; s < strays; s++) begin
            beat(1'b0, 1'b0, 8'($urandom), 1'b0, ok);
            if (!ok) check("stray_accept_timeout", 0, 1);
        end
        for (int i = 0; i < n; i++)
            pl.push_back(mode == 0 ? 8'($urandom) : mode == 1 ? 8'(i) : 8'(8'h31 + i));
        k = und > 0 ? und : n;
        for (int i = 0; i < k; i++) begin
            beat(i == 0, i == n - 1, pl[i], i == err_at, ok);
            if (!ok) begin
                check("beat_accept_timeout", 0, 1);
                break;
            end
        end
        mac.valid = 0;
        if (und > 0) begin
            @(posedge clk);
            #1;
        end
        if (npk > 0) exp_gap.push_back(IPG + strays);
        repeat (7) exp_q.push_back({1'b0, PREAMBLE_BYTE});
        exp_q.push_back({1'b0, SFD});
        for (int i = 0; i < k; i++) exp_q.push_back({i == err_at, pl[i]});
        if (und > 0) begin
            exp_q.push_back(9'h100);
            len = 8 + k + 1;
        end else begin
            fr = pl;
            while (fr.size() < MIN) begin
                fr.push_back(8'h00);
                exp_q.push_back(9'h000);
            end
            len = 8 + fr.size();
`ifdef RGMII_TX_FCS_EN
            begin
                logic [31:0] c;
                c = fcs_ref(fr);
                for (int b = 0; b < 4; b++) exp_q.push_back({1'b0, c[8*b +: 8]});
                len += 4;
            end
`endif
        end
        exp_len.push_back(len);
        npk++;
    endtask

    task automatic finish_test(input string tag);
        int m;
        repeat (250) @(posedge clk);
        check({tag, ":frames"}, len_q.size(), exp_len.size());
        m = len_q.size() < exp_len.size() ? len_q.size() : exp_len.size();
        for (int i = 0; i < m; i++) check($sformatf("%s:len%0d", tag, i), len_q[i], exp_len[i]);
        check({tag, ":bytes"}, got_q.size(), exp_q.size());
        m = got_q.size() < exp_q.size() ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) check($sformatf("%s:byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        check({tag, ":gaps"}, gap_q.size(), exp_gap.size());
        m = gap_q.size() < exp_gap.size() ? gap_q.size() : exp_gap.size();
        for (int i = 0; i < m; i++) check($sformatf("%s:gap%0d", tag, i), gap_q[i], exp_gap[i]);
        check({tag, ":idle_clean"}, bad_idle, 0);
    endtask

    initial begin
        logic r;
        mac.valid = 1; mac.startofpacket = 0; mac.endofpacket = 0; mac.data = 8'h5A; mac.error = 0;
        #20;
        check("rst_txd", 32'(txd), 32'h0);
        check("rst_en", 32'(tx_en), 0);
        check("rst_er", 32'(tx_er), 0);
        check("rst_ready", 32'(mac.ready), 0);

        do_reset();
        mac.valid = 1; mac.startofpacket = 1; mac.endofpacket = 0; mac.data = 8'hA0; mac.error = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            r = mac.ready;
            @(posedge clk);
            #1;
            if (r) begin
                mac.startofpacket = 0;
                mac.data = mac.data + 8'd1;
            end
        end
        check("midrst_en_before", 32'(tx_en), 1);
        rst_n = 0;
        #1;
        check("midrst_en", 32'(tx_en), 0);
        check("midrst_er", 32'(tx_er), 0);
        check("midrst_txd", 32'(txd), 0);
        check("midrst_ready", 32'(mac.ready), 0);
        do_reset();
        send_pkt(20, 0, 0, -1, 0);
        finish_test("after_reset");

        do_reset();
        send_pkt(64, 1, 0, -1, 0);
        finish_test("inc64");

        do_reset();
        send_pkt(10, 0, 0, -1, 0);
        send_pkt(1, 0, 0, -1, 0);
        finish_test("pad");

        do_reset();
        send_pkt(100, 0, 20, -1, 0);
        send_pkt(9, 2, 0, -1, 0);
        finish_test("underrun");

        do_reset();
        send_pkt(30, 0, 0, 5, 3);
        send_pkt(25, 0, 0, -1, 0);
        send_pkt(12, 2, 0, -1, 2);
        finish_test("b2b");

        for (int round = 0; round < 3; round++) begin
            do_reset();
            for (int p = 0; p < 5; p++) begin
                int n, und, err;
                n   = $urandom_range(1, 90);
                und = (n > 1 && $urandom_range(0, 4) == 0) ? $urandom_range(1, n - 1) : 0;
                err = $urandom_range(0, 3) == 0 ? $urandom_range(0, n - 1) : -1;
                send_pkt(n, 0, und, err, $urandom_range(0, 2));
            end
            finish_test($sformatf("rand%0d", round));
        end

        kat_c = CRC32_INIT;
        for (int i = 0; i < 9; i++) begin
            kat_d = 8'(8'h31 + i);
            #1;
            kat_c = kat_o;
        end
        check("crc32_d8_kat", ~kat_c, 32'hCBF4_3926);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
